loop_exec_sequencer: RTL and testbench
======================================

Name: loop_exec_sequencer

Overview:
- Sequences one program execution from the instruction buffer.
- Gates host instruction writes into the buffer.
- On start, drives the looping / loop_en / last_loop controls of the buffer read controller.
- Counts loop-body passes from end_of_loop and terminates on buffer_reset, reporting completion to the host-side command logic.

Parameters:
- WIDTH, 13, buffer address width
- CNT_W, 16, loop-count width
- LOOP_START, 512, first buffer address of the loop body

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- host_wr_valid  in  1  host offers an instruction word
- host_wr_ready  out  1  word accepted this cycle
- buf_wr_en  out  1  write enable to buffer (wr_en); app_en held externally
- buf_full  in  1  buffer full flag
- buf_wr_addr  in  WIDTH  current buffer write address (instruction count)
- start  in  1  one-cycle execute request
- loop_count  in  CNT_W  total loop-body passes N, sampled on accepted start
- looping  out  1  to read controller
- loop_en  out  1  to read controller
- last_loop  out  1  to read controller
- end_of_loop  in  1  from read controller
- buffer_reset  in  1  registered end-of-program pulse from buffer controller
- busy  out  1  execution in progress
- done  out  1  one-cycle completion pulse
- start_err  out  1  one-cycle pulse: start rejected
- iter_cnt  out  CNT_W  completed loop-body passes

Behaviour:
- Reset (rst=0, async): state IDLE; every output 0; iter_cnt=0, N register 0, eol_q=0.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - host_wr_ready = ~buf_full; buf_wr_en = host_wr_valid & ~buf_full (combinational, zero latency).
  - start with buf_wr_addr==0: start_err=1 next cycle, stay IDLE.
  - Otherwise latch N=loop_count, clear iter_cnt, go RUN.
- Latched flags:
  - loop_en_r = (N>=2) & (buf_wr_addr > LOOP_START).
  - Buffer contents entirely below LOOP_START means no body: loop_en_r=0.
- RUN:
  - looping=1, busy=1, host_wr_ready=0, buf_wr_en=0; host writes stall, start ignored.
  - loop_en = loop_en_r.
- Pass counting:
  - eol_q registers end_of_loop each cycle.
  - A pass completes on the falling edge (eol_q=1, end_of_loop=0) while RUN.
  - Level-based counting is wrong: end_of_loop stays high across both port wraps of one pass.
  - On completion, iter_cnt increments, saturating at all-ones.
- last_loop:
  - Registered; next value = loop_en_r & (iter_cnt_ns >= N-1).
  - Valid ≥2 cycles before the next wrap decision, given the minimum body length of 4 instructions (shorter bodies unsupported).
  - With loop_en_r=0, last_loop stays 0.
- Exit from RUN: buffer_reset=1 → FLUSH next cycle; looping, loop_en, last_loop drop to 0 on that edge.
- FLUSH: one cycle; done=1; busy=1; next state IDLE.
- buffer_reset in IDLE or FLUSH is ignored.
- start while buffer_reset=1 in IDLE: start takes priority.
- Reset mid-RUN: all outputs 0 immediately; the buffer controller is reset by the same reset domain.
- N=0 and N=1 are equivalent: single pass, no loop-back.

Test Plan:
- Writes: 5 host words with buf_full=0 → 5 buf_wr_en pulses, host_wr_ready=1 each cycle; buf_full=1 → host_wr_ready=0, no buf_wr_en.
- Empty start: start with buf_wr_addr=0 → start_err pulse, looping stays 0, state IDLE.
- Looped run: buf_wr_addr=520, loop_count=3, 3 end_of_loop high/low pulses → loop_en=1; last_loop=0 until the 2nd falling edge, then 1; buffer_reset after the 3rd pass → done one cycle later, iter_cnt=3, looping=0.
- No body: buf_wr_addr=100, loop_count=5 → loop_en=0 and last_loop=0 throughout; buffer_reset → done pulse.
- Busy gating: host_wr_valid held during RUN → buf_wr_en=0 until IDLE, then accepted; a second start during RUN is ignored.
- Async reset: rst=0 mid-RUN, asserted between clock edges → looping, busy and last_loop go 0 without a clock edge; after release, IDLE with iter_cnt=0.

Source files
------------

// File: rtl/loop_exec_sequencer.sv
// Execution sequencer for the instruction buffer: gates host writes, drives the
// read controller's loop controls and counts loop-body passes until end of program.
module loop_exec_sequencer #(
  parameter int WIDTH      = 13,
  parameter int CNT_W      = 16,
  parameter int LOOP_START = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             host_wr_valid,
  output logic             host_wr_ready,
  output logic             buf_wr_en,
  input  logic             buf_full,
  input  logic [WIDTH-1:0] buf_wr_addr,
  input  logic             start,
  input  logic [CNT_W-1:0] loop_count,
  output logic             looping,
  output logic             loop_en,
  output logic             last_loop,
  input  logic             end_of_loop,
  input  logic             buffer_reset,
  output logic             busy,
  output logic             done,
  output logic             start_err,
  output logic [CNT_W-1:0] iter_cnt
);

  // state | meaning
  // IDLE  | host may write the buffer; waiting for start
  // RUN   | program executing; passes counted from end_of_loop falling edges
  // FLUSH | one-cycle completion after buffer_reset; done pulses
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             eol_q;
  logic             loop_en_q, loop_en_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic             pass_done;

  // end_of_loop spans both port wraps of one pass, so only its falling edge counts
  assign pass_done = eol_q & ~end_of_loop;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    iter_d    = iter_q;
    loop_en_d = loop_en_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (buf_wr_addr == '0) begin
            err_d = 1'b1;
          end else begin
            n_d       = loop_count;
            iter_d    = '0;
            loop_en_d = (loop_count >= CNT_W'(2)) && (buf_wr_addr > WIDTH'(LOOP_START));
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        if (pass_done && (iter_q != '1)) iter_d = iter_q + CNT_W'(1);
        if (buffer_reset) begin
          state_d   = FLUSH;
          loop_en_d = 1'b0;
        end
      end
      FLUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // N-1 wraps for N=0, but loop_en_d is already 0 whenever N<2
    last_d = (state_d == RUN) && loop_en_d && (iter_d >= (n_d - CNT_W'(1)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      n_q       <= '0;
      iter_q    <= '0;
      eol_q     <= 1'b0;
      loop_en_q <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      iter_q    <= iter_d;
      eol_q     <= end_of_loop;
      loop_en_q <= loop_en_d;
      last_q    <= last_d;
      err_q     <= err_d;
    end
  end

  // rst gates the write path so every output is 0 while held in reset
  assign host_wr_ready = rst && (state_q == IDLE) && !buf_full;
  assign buf_wr_en     = host_wr_ready && host_wr_valid;
  assign looping       = (state_q == RUN);
  assign loop_en       = (state_q == RUN) && loop_en_q;
  assign last_loop     = last_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FLUSH);
  assign start_err     = err_q;
  assign iter_cnt      = iter_q;

endmodule

// File: tb/tb_loop_exec_sequencer.sv
// Directed bench for loop_exec_sequencer; expected write counts and final pass
// counts go through a scoreboard queue and are checked when the DUT reports them.
module tb_loop_exec_sequencer;

  localparam int WIDTH = 13;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             host_wr_valid = 1'b0;
  logic             host_wr_ready;
  logic             buf_wr_en;
  logic             buf_full = 1'b0;
  logic [WIDTH-1:0] buf_wr_addr = '0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] loop_count = '0;
  logic             looping, loop_en, last_loop;
  logic             end_of_loop = 1'b0;
  logic             buffer_reset = 1'b0;
  logic             busy, done, start_err;
  logic [CNT_W-1:0] iter_cnt;

  int n_err = 0;
  int n_chk = 0;
  int wr_seen = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) if (buf_wr_en) wr_seen++;

  loop_exec_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W), .LOOP_START(512)) dut (
    .clk(clk), .rst(rst),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .buf_wr_en(buf_wr_en), .buf_full(buf_full), .buf_wr_addr(buf_wr_addr),
    .start(start), .loop_count(loop_count),
    .looping(looping), .loop_en(loop_en), .last_loop(last_loop),
    .end_of_loop(end_of_loop), .buffer_reset(buffer_reset),
    .busy(busy), .done(done), .start_err(start_err), .iter_cnt(iter_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one loop-body pass: end_of_loop high two cycles, then low
  task automatic do_pass(input int k, input logic exp_last, input logic exp_loop_en);
    @(negedge clk); end_of_loop = 1'b1;
    @(negedge clk);
    @(negedge clk); end_of_loop = 1'b0;
    @(negedge clk); #1;
    chk($sformatf("iter_after_pass%0d", k), 32'(iter_cnt), 32'(k));
    chk($sformatf("last_after_pass%0d", k), 32'(last_loop), 32'(exp_last));
    chk($sformatf("loop_en_pass%0d", k), 32'(loop_en), 32'(exp_loop_en));
  endtask

  task automatic finish_run(input string tag);
    int exp_iter;
    @(negedge clk); buffer_reset = 1'b1;
    @(negedge clk); buffer_reset = 1'b0; #1;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_flush"}, 32'(busy), 32'd1);
    chk({tag, "_looping_flush"}, 32'(looping), 32'd0);
    chk({tag, "_loop_en_flush"}, 32'(loop_en), 32'd0);
    chk({tag, "_last_flush"}, 32'(last_loop), 32'd0);
    if (exp_q.size() == 0) chk({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
    else begin
      exp_iter = exp_q.pop_front();
      chk({tag, "_iter_final"}, 32'(iter_cnt), 32'(exp_iter));
    end
    @(negedge clk); #1;
    chk({tag, "_done_pulse_end"}, 32'(done), 32'd0);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int wr_base;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_looping", 32'(looping), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_iter", 32'(iter_cnt), 32'd0);
    chk("rst_ready", 32'(host_wr_ready), 32'd0);
    chk("rst_last", 32'(last_loop), 32'd0);
    @(negedge clk); rst = 1'b1;

    // five host writes
    exp_q.push_back(5);
    @(negedge clk);
    wr_base = wr_seen;
    for (int i = 0; i < 5; i++) begin
      host_wr_valid = 1'b1; #1;
      chk($sformatf("wr_ready_%0d", i), 32'(host_wr_ready), 32'd1);
      chk($sformatf("wr_en_%0d", i), 32'(buf_wr_en), 32'd1);
      @(negedge clk);
    end
    host_wr_valid = 1'b0;
    @(negedge clk);
    chk("wr_count", 32'(wr_seen - wr_base), 32'(exp_q.pop_front()));
    buf_full = 1'b1; host_wr_valid = 1'b1; #1;
    chk("full_ready", 32'(host_wr_ready), 32'd0);
    chk("full_wr_en", 32'(buf_wr_en), 32'd0);
    @(negedge clk); buf_full = 1'b0; host_wr_valid = 1'b0;

    // empty buffer start
    buf_wr_addr = '0; start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    chk("empty_start_err", 32'(start_err), 32'd1);
    chk("empty_looping", 32'(looping), 32'd0);
    chk("empty_busy", 32'(busy), 32'd0);
    @(negedge clk); #1;
    chk("empty_err_pulse_end", 32'(start_err), 32'd0);

    // looped run: N=3, body present, with busy gating and a second start
    buf_wr_addr = 13'd520; loop_count = 16'd3; start = 1'b1;
    exp_q.push_back(3);
    @(negedge clk); start = 1'b0; host_wr_valid = 1'b1; #1;
    chk("run_looping", 32'(looping), 32'd1);
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_loop_en", 32'(loop_en), 32'd1);
    chk("run_last_init", 32'(last_loop), 32'd0);
    chk("run_iter_init", 32'(iter_cnt), 32'd0);
    chk("run_wr_gated", 32'(buf_wr_en), 32'd0);
    chk("run_ready_gated", 32'(host_wr_ready), 32'd0);
    @(negedge clk); start = 1'b1; loop_count = 16'd1;
    @(negedge clk); start = 1'b0; #1;
    chk("run_restart_err", 32'(start_err), 32'd0);
    chk("run_restart_loop_en", 32'(loop_en), 32'd1);
    chk("run_restart_looping", 32'(looping), 32'd1);
    do_pass(1, 1'b0, 1'b1);
    do_pass(2, 1'b1, 1'b1);
    do_pass(3, 1'b1, 1'b1);
    chk("run_wr_still_gated", 32'(buf_wr_en), 32'd0);
    finish_run("loop");
    chk("after_run_wr_en", 32'(buf_wr_en), 32'd1);
    chk("after_run_looping", 32'(looping), 32'd0);
    @(negedge clk); host_wr_valid = 1'b0;

    // no loop body: contents below LOOP_START
    buf_wr_addr = 13'd100; loop_count = 16'd5; start = 1'b1;
    exp_q.push_back(2);
    @(negedge clk); start = 1'b0; #1;
    chk("nobody_looping", 32'(looping), 32'd1);
    chk("nobody_loop_en", 32'(loop_en), 32'd0);
    do_pass(1, 1'b0, 1'b0);
    do_pass(2, 1'b0, 1'b0);
    finish_run("nobody");

    // async reset mid-run
    buf_wr_addr = 13'd600; loop_count = 16'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    do_pass(1, 1'b1, 1'b1);
    @(negedge clk); #2; rst = 1'b0; #1;
    chk("arst_looping", 32'(looping), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_last", 32'(last_loop), 32'd0);
    chk("arst_loop_en", 32'(loop_en), 32'd0);
    chk("arst_iter", 32'(iter_cnt), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_iter", 32'(iter_cnt), 32'd0);
    chk("post_rst_ready", 32'(host_wr_ready), 32'd1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
